// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck, seeded by the upstream counter.
// A used-card mask is probed linearly from the seeded candidate until a free card is found.
module card_dealer #(
    parameter int WIDTH = 12
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Draw,
    input  logic             i_Shuffle,
    output logic             o_Busy,
    output logic             o_Valid,
    output logic [5:0]       o_Card,
    output logic [1:0]       o_Suit,
    output logic [3:0]       o_Rank,
    output logic [3:0]       o_Points,
    output logic [5:0]       o_Remaining,
    output logic             o_Empty
);

    typedef enum logic {IDLE, PROBE} state_t;

    state_t      r_State;
    state_t      w_NextState;

    logic [51:0] r_Used;
    logic [5:0]  r_Cand;
    logic [5:0]  r_Remaining;
    logic        r_Valid;
    logic [5:0]  r_Card;
    logic [1:0]  r_Suit;
    logic [3:0]  r_Rank;
    logic [3:0]  r_Points;

    logic [5:0]  w_SeedLow;
    logic [5:0]  w_SeedCand;
    logic [5:0]  w_NextCand;
    logic        w_Hit;
    logic        w_Empty;
    logic        w_Accept;
    logic [1:0]  w_Suit;
    logic [5:0]  w_SuitBase;
    logic [5:0]  w_RankIdx;
    logic [3:0]  w_Rank;
    logic [3:0]  w_Points;
    logic [WIDTH-1:0] w_unusedSeed;

    // Only the low six seed bits carry entropy; 52..63 fold back onto 0..11.
    assign w_unusedSeed = i_Seed;
    assign w_SeedLow    = i_Seed[5:0];
    assign w_SeedCand   = (w_SeedLow >= 6'd52) ? (w_SeedLow - 6'd52) : w_SeedLow;
    assign w_NextCand   = (r_Cand == 6'd51) ? 6'd0 : (r_Cand + 6'd1);
    assign w_Empty      = (r_Remaining == 6'd0);
    assign w_Hit        = (r_State == PROBE) && !r_Used[r_Cand];
    assign w_Accept     = (r_State == IDLE) && i_Draw && !w_Empty && !i_Shuffle;

    always_comb begin
        w_Suit     = 2'd0;
        w_SuitBase = 6'd0;
        if (r_Cand >= 6'd39) begin
            w_Suit     = 2'd3;
            w_SuitBase = 6'd39;
        end else if (r_Cand >= 6'd26) begin
            w_Suit     = 2'd2;
            w_SuitBase = 6'd26;
        end else if (r_Cand >= 6'd13) begin
            w_Suit     = 2'd1;
            w_SuitBase = 6'd13;
        end
    end

    assign w_RankIdx = r_Cand - w_SuitBase;
    assign w_Rank    = w_RankIdx[3:0] + 4'd1;
    assign w_Points  = (w_Rank >= 4'd10) ? 4'd10 : w_Rank;

    always_ff @(posedge clk_50M or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        if (i_Shuffle) begin
            w_NextState = IDLE;
        end else begin
            case (r_State)
                IDLE:    if (w_Accept) w_NextState = PROBE;
                PROBE:   if (w_Hit)    w_NextState = IDLE;
                default: w_NextState = IDLE;
            endcase
        end
    end

    // Shuffle wins over everything, including a probe that would hit this cycle.
    always_ff @(posedge clk_50M or negedge i_Reset) begin
        if (!i_Reset) begin
            r_Used      <= '0;
            r_Cand      <= '0;
            r_Remaining <= 6'd52;
            r_Valid     <= 1'b0;
            r_Card      <= '0;
            r_Suit      <= '0;
            r_Rank      <= '0;
            r_Points    <= '0;
        end else if (i_Shuffle) begin
            r_Used      <= '0;
            r_Remaining <= 6'd52;
            r_Valid     <= 1'b0;
        end else begin
            r_Valid <= 1'b0;
            if (w_Accept) begin
                r_Cand <= w_SeedCand;
            end else if (r_State == PROBE) begin
                if (w_Hit) begin
                    r_Used[r_Cand] <= 1'b1;
                    r_Remaining    <= r_Remaining - 6'd1;
                    r_Card         <= r_Cand;
                    r_Suit         <= w_Suit;
                    r_Rank         <= w_Rank;
                    r_Points       <= w_Points;
                    r_Valid        <= 1'b1;
                end else begin
                    r_Cand <= w_NextCand;
                end
            end
        end
    end

    always_comb begin
        o_Busy      = (r_State == PROBE);
        o_Valid     = r_Valid;
        o_Card      = r_Card;
        o_Suit      = r_Suit;
        o_Rank      = r_Rank;
        o_Points    = r_Points;
        o_Remaining = r_Remaining;
        o_Empty     = w_Empty;
    end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: draws push expected cards, a monitor checks each strobe.
module tb_card_dealer;

    logic        clk_50M;
    logic        i_Reset;
    logic [11:0] i_Seed;
    logic        i_Draw;
    logic        i_Shuffle;
    logic        o_Busy;
    logic        o_Valid;
    logic [5:0]  o_Card;
    logic [1:0]  o_Suit;
    logic [3:0]  o_Rank;
    logic [3:0]  o_Points;
    logic [5:0]  o_Remaining;
    logic        o_Empty;

    typedef struct {
        int card;
        int suit;
        int rank;
        int points;
        int rem;
    } exp_t;

    exp_t scoreQ[$];
    exp_t monExp;
    int   vectorCount = 0;
    int   missCount   = 0;

    card_dealer #(.WIDTH(12)) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_Seed      (i_Seed),
        .i_Draw      (i_Draw),
        .i_Shuffle   (i_Shuffle),
        .o_Busy      (o_Busy),
        .o_Valid     (o_Valid),
        .o_Card      (o_Card),
        .o_Suit      (o_Suit),
        .o_Rank      (o_Rank),
        .o_Points    (o_Points),
        .o_Remaining (o_Remaining),
        .o_Empty     (o_Empty)
    );

    initial begin
        clk_50M = 1'b0;
        forever #10 clk_50M = ~clk_50M;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectCard(input int card, input int suit, input int rank,
                              input int points, input int rem);
        exp_t e;
        e.card = card; e.suit = suit; e.rank = rank; e.points = points; e.rem = rem;
        scoreQ.push_back(e);
    endtask

    task automatic expectAuto(input int card, input int rem);
        int rank;
        rank = (card % 13) + 1;
        expectCard(card, card / 13, rank, (rank > 10) ? 10 : rank, rem);
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    // Issue one draw and measure the edges from acceptance to the valid strobe.
    task automatic applyStimulus(input string name, input logic [11:0] seed, input int expLat);
        int lat;
        bit got;
        i_Seed = seed;
        i_Draw = 1'b1;
        tick();
        i_Draw = 1'b0;
        checkOutput({name, "_busy"}, o_Busy, 1);
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            lat++;
            if (o_Valid) got = 1'b1;
        end
        if (!got) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL %s_timeout: got no strobe after %0d edges, expected latency %0d",
                     name, lat, expLat);
        end else begin
            checkOutput({name, "_latency"}, lat, expLat);
            checkOutput({name, "_busy_after"}, o_Busy, 0);
        end
    endtask

    task automatic pulseShuffle();
        i_Shuffle = 1'b1;
        tick();
        i_Shuffle = 1'b0;
    endtask

    // Every strobe must match the oldest outstanding expectation; stray strobes are errors.
    always @(negedge clk_50M) begin
        if (i_Reset === 1'b1 && o_Valid === 1'b1) begin
            if (scoreQ.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL unexpected_valid: got card %0d, expected no strobe", o_Card);
            end else begin
                monExp = scoreQ.pop_front();
                checkOutput("card",      o_Card,      monExp.card);
                checkOutput("suit",      o_Suit,      monExp.suit);
                checkOutput("rank",      o_Rank,      monExp.rank);
                checkOutput("points",    o_Points,    monExp.points);
                checkOutput("remaining", o_Remaining, monExp.rem);
                checkOutput("empty",     o_Empty,     (monExp.rem == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        i_Reset   = 1'b0;
        i_Seed    = '0;
        i_Draw    = 1'b0;
        i_Shuffle = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        checkOutput("reset_valid",     o_Valid,     0);
        checkOutput("reset_busy",      o_Busy,      0);
        checkOutput("reset_remaining", o_Remaining, 52);
        checkOutput("reset_empty",     o_Empty,     0);
        checkOutput("reset_card",      o_Card,      0);
        checkOutput("reset_rank",      o_Rank,      0);
        i_Reset = 1'b1;
        tick();

        $display("[TB] basic, face card and seed folding");
        expectCard(5, 0, 6, 6, 51);
        applyStimulus("seed5", 12'd5, 1);
        expectCard(38, 2, 13, 10, 50);
        applyStimulus("seed38", 12'd38, 1);
        expectCard(11, 0, 12, 10, 49);
        applyStimulus("seedFFF", 12'hFFF, 1);

        $display("[TB] collisions and wrap-around");
        expectCard(6, 0, 7, 7, 48);
        applyStimulus("seed5_again", 12'd5, 2);
        expectCard(51, 3, 13, 10, 47);
        applyStimulus("seed51", 12'd51, 1);
        expectCard(0, 0, 1, 1, 46);
        applyStimulus("seed51_wrap", 12'd51, 2);

        $display("[TB] shuffle aborts a long probe");
        pulseShuffle();
        checkOutput("shuffle_remaining", o_Remaining, 52);
        for (int n = 1; n <= 10; n++) begin
            expectAuto(n - 1, 52 - n);
            applyStimulus("fill", 12'd0, n);
        end
        i_Seed = 12'd0;
        i_Draw = 1'b1;
        tick();
        i_Draw = 1'b0;
        repeat (5) tick();
        checkOutput("probe_busy", o_Busy, 1);
        pulseShuffle();
        checkOutput("abort_busy",      o_Busy,      0);
        checkOutput("abort_remaining", o_Remaining, 52);
        repeat (15) tick();
        checkOutput("abort_still_idle", o_Busy, 0);

        $display("[TB] shuffle beats a same-cycle draw");
        i_Seed    = 12'd5;
        i_Draw    = 1'b1;
        i_Shuffle = 1'b1;
        tick();
        i_Draw    = 1'b0;
        i_Shuffle = 1'b0;
        checkOutput("shuffle_draw_busy", o_Busy, 0);
        repeat (3) tick();
        expectCard(5, 0, 6, 6, 51);
        applyStimulus("after_shuffle", 12'd5, 1);

        $display("[TB] exhaustion");
        pulseShuffle();
        for (int n = 1; n <= 52; n++) begin
            expectAuto(n - 1, 52 - n);
            applyStimulus("exhaust", 12'd0, n);
        end
        checkOutput("exhaust_empty",     o_Empty,     1);
        checkOutput("exhaust_remaining", o_Remaining, 0);
        i_Seed = 12'd0;
        i_Draw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("empty_draw_busy", o_Busy, 0);
        end
        i_Draw = 1'b0;
        repeat (3) tick();

        $display("[TB] asynchronous reset mid-probe");
        pulseShuffle();
        for (int n = 1; n <= 3; n++) begin
            expectAuto(n - 1, 52 - n);
            applyStimulus("prefill", 12'd0, n);
        end
        i_Seed = 12'd0;
        i_Draw = 1'b1;
        tick();
        i_Draw = 1'b0;
        tick();
        checkOutput("pre_reset_busy", o_Busy, 1);
        #4;
        i_Reset = 1'b0;
        #1;
        checkOutput("async_valid",     o_Valid,     0);
        checkOutput("async_busy",      o_Busy,      0);
        checkOutput("async_remaining", o_Remaining, 52);
        checkOutput("async_card",      o_Card,      0);
        checkOutput("async_empty",     o_Empty,     0);
        @(posedge clk_50M);
        #1;
        i_Reset = 1'b1;
        expectCard(5, 0, 6, 6, 51);
        applyStimulus("post_reset", 12'd5, 1);

        repeat (3) tick();
        checkOutput("scoreboard_drained", scoreQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
